conv_tile_loader: RTL
=====================

CONV_TILE_LOADER -- requirements
Module: conv_tile_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter TILE_DIM, default 6, input tile side length.
REQ-003 SHALL have parameter K_DIM, default 3, kernel side length.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port s_data, input, DATA_W, stream byte.
REQ-007 SHALL have port s_valid, input, 1, s_data valid.
REQ-008 SHALL have port s_ready, output, 1, loader accepts the beat.
REQ-009 SHALL have port s_last, input, 1, final beat of the frame.
REQ-010 SHALL have port input_tile, output, [TILE_DIM][TILE_DIM] x DATA_W, registered tile to the convolution engine.
REQ-011 SHALL have port kernel, output, [K_DIM][K_DIM] x DATA_W, registered kernel.
REQ-012 SHALL have port conv_start, output, 1, single-cycle start pulse to the engine.
REQ-013 SHALL have port conv_done, input, 1, engine completion.
REQ-014 SHALL have port busy, output, 1, high in any state other than LOAD.
REQ-015 SHALL have port frame_err, output, 1, sticky framing error.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT.
REQ-017 SHALL accept a beat only when s_valid && s_ready; s_ready = (state == LOAD).
REQ-018 SHALL write beats row-major: beats 0..TILE_DIM^2-1 (0..35) into input_tile[r][c], then beats 36..44 into kernel[r][c].
REQ-019 SHALL move LOAD->START on acceptance of the final expected beat with s_last=1; conv_start SHALL be high for exactly the one START cycle, then WAIT.
REQ-020 SHALL hold input_tile and kernel constant from the final beat until leaving WAIT.
REQ-021 SHALL move WAIT->LOAD on the cycle conv_done=1, with the beat counter at 0; s_ready is high the following cycle.
REQ-022 SHALL ignore conv_done outside WAIT.
REQ-023 SHALL treat as a framing error s_last=1 on a non-final beat or s_last=0 on the final beat: set frame_err, reset the beat counter to 0, stay in LOAD, and not pulse conv_start.
REQ-024 SHALL keep already-written array contents after an errored frame; the next frame overwrites them.
REQ-025 SHALL keep frame_err set until rst.

Reset
REQ-026 SHALL, on rst, immediately enter LOAD and clear the beat counter, input_tile, kernel, conv_start, frame_err and the kernel-valid flag, including mid-frame or in WAIT.
REQ-027 SHALL drive s_ready=1 and busy=0 while out of reset in LOAD.

Configuration
REQ-028 SHALL, with macro CONV_LOADER_KERNEL_REUSE_EN defined, add input port reuse_kernel (1 bit), sampled on beat 0.
REQ-029 SHALL, in that configuration, when reuse_kernel=1 and kernel-valid=1, make the frame 36 beats with s_last expected on beat 35 and leave kernel unchanged.
REQ-030 SHALL, in that configuration, when reuse_kernel=1 and kernel-valid=0, use the full 45-beat frame.
REQ-031 SHALL set kernel-valid on each successful 45-beat frame.
REQ-032 SHALL, without the macro, have no reuse_kernel port and use only 45-beat frames.

Structure
REQ-033 SHALL place DATA_W, TILE_DIM and K_DIM defaults, the derived frame lengths (36, 45) and the state enum in shared package npu_pkg.
REQ-034 SHALL be a single module with no sub-module.

Verification
REQ-035 SHALL test: 45 beats with values 0..44 and s_last on beat 44 -> input_tile[0][0]=0, input_tile[5][5]=35, kernel[2][2]=44; conv_start high for 1 cycle, 1 cycle after the last beat.
REQ-036 SHALL test: conv_done held low for 20 cycles after start -> s_ready=0 and outputs stable; conv_done pulse -> s_ready=1 on the next cycle.
REQ-037 SHALL test: s_last on beat 10 -> frame_err=1, no conv_start; a following correct 45-beat frame -> conv_start pulses and frame_err stays 1.
REQ-038 SHALL test: rst asserted at beat 20 -> all outputs 0 asynchronously; the next frame loads from beat 0.
REQ-039 SHALL test, with the macro: a 45-beat frame, then a 36-beat frame with reuse_kernel=1 -> kernel retains its first-frame values and conv_start pulses after beat 35.
REQ-040 SHALL test: s_valid toggled randomly under back-pressure -> the same array contents as the gap-free run.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU defaults, derived frame lengths and the tile loader state encoding.
package npu_pkg;

  localparam int NPU_DATA_W      = 8;
  localparam int NPU_TILE_DIM    = 6;
  localparam int NPU_K_DIM       = 3;
  localparam int NPU_TILE_BEATS  = NPU_TILE_DIM * NPU_TILE_DIM;          // 36
  localparam int NPU_FRAME_BEATS = NPU_TILE_BEATS + NPU_K_DIM * NPU_K_DIM; // 45

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } ldr_state_e;

  function automatic int tile_beats(input int td);
    return td * td;
  endfunction

  function automatic int frame_beats(input int td, input int kd);
    return td * td + kd * kd;
  endfunction

endpackage

// File: rtl/conv_tile_loader.sv
// Streams a row-major tile + kernel frame into registered arrays and hands it to the conv engine.
// Optional CONV_LOADER_KERNEL_REUSE_EN: tile-only frames that keep the previous kernel.
module conv_tile_loader
  import npu_pkg::*;
#(
  parameter int DATA_W   = NPU_DATA_W,
  parameter int TILE_DIM = NPU_TILE_DIM,
  parameter int K_DIM    = NPU_K_DIM
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_W-1:0]                         s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic                                      s_last,
`ifdef CONV_LOADER_KERNEL_REUSE_EN
  input  logic                                      reuse_kernel,
`endif
  output logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] input_tile,
  output logic [K_DIM-1:0][K_DIM-1:0][DATA_W-1:0]       kernel,
  output logic                                      conv_start,
  input  logic                                      conv_done,
  output logic                                      busy,
  output logic                                      frame_err
);

  localparam int TILE_BEATS  = tile_beats(TILE_DIM);
  localparam int FRAME_BEATS = frame_beats(TILE_DIM, K_DIM);
  localparam int CNT_W       = $clog2(FRAME_BEATS);

  ldr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              conv_start_q, conv_start_d;
  logic              frame_err_q, frame_err_d;
  logic              kvalid_q, kvalid_d;
  logic              reuse_q, reuse_d;
  logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_W-1:0] tile_q, tile_d;
  logic [K_DIM-1:0][K_DIM-1:0][DATA_W-1:0]       kern_q, kern_d;

  logic              reuse_in, reuse_now, is_final, accept;
  logic [CNT_W-1:0]  last_idx;

`ifdef CONV_LOADER_KERNEL_REUSE_EN
  assign reuse_in = reuse_kernel;
`else
  assign reuse_in = 1'b0;
`endif

  // s_ready drops during reset so nothing is claimed as accepted then
  assign s_ready    = (state_q == LOAD) && !rst;
  assign busy       = (state_q != LOAD);
  assign accept     = s_valid && s_ready;
  assign conv_start = conv_start_q;
  assign frame_err  = frame_err_q;
  assign input_tile = tile_q;
  assign kernel     = kern_q;

  // Reuse decision is latched on beat 0 and governs the rest of the frame
  assign reuse_now = (cnt_q == '0) ? (reuse_in && kvalid_q) : reuse_q;
  assign last_idx  = reuse_now ? CNT_W'(TILE_BEATS - 1) : CNT_W'(FRAME_BEATS - 1);
  assign is_final  = (cnt_q == last_idx);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    conv_start_d = 1'b0;
    frame_err_d  = frame_err_q;
    kvalid_d     = kvalid_q;
    reuse_d      = reuse_q;
    tile_d       = tile_q;
    kern_d       = kern_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          for (int r = 0; r < TILE_DIM; r++)
            for (int c = 0; c < TILE_DIM; c++)
              if (cnt_q == CNT_W'(r * TILE_DIM + c)) tile_d[r][c] = s_data;
          for (int r = 0; r < K_DIM; r++)
            for (int c = 0; c < K_DIM; c++)
              if (cnt_q == CNT_W'(TILE_BEATS + r * K_DIM + c)) kern_d[r][c] = s_data;
          reuse_d = reuse_now;
          if (s_last != is_final) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else if (is_final) begin
            state_d      = START;
            cnt_d        = '0;
            conv_start_d = 1'b1;
            if (!reuse_now) kvalid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (conv_done) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      conv_start_q <= 1'b0;
      frame_err_q  <= 1'b0;
      kvalid_q     <= 1'b0;
      reuse_q      <= 1'b0;
      tile_q       <= '0;
      kern_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      conv_start_q <= conv_start_d;
      frame_err_q  <= frame_err_d;
      kvalid_q     <= kvalid_d;
      reuse_q      <= reuse_d;
      tile_q       <= tile_d;
      kern_q       <= kern_d;
    end
  end

endmodule
